// File: rtl/sort_checker_if.sv
// sort_checker_if: start/rdy/done handshake, RAM read port and scan results
interface sort_checker_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic start, rdy, done, pass;
  logic [ADDR_W-1:0] addr, err_addr;
  logic [DATA_W-1:0] rddata, min_val, max_val;
  logic [DATA_W+ADDR_W-1:0] sum;
  modport master(output start, rddata, input rdy, done, addr, pass, err_addr, min_val, max_val, sum);
  modport slave(input start, rddata, output rdy, done, addr, pass, err_addr, min_val, max_val, sum);
endinterface

// File: rtl/sort_checker.sv
// sort_checker: scans N RAM words from BASE, checks non-decreasing order, reports first violation, min/max and checksum
module sort_checker #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int N = 256,
  parameter int BASE = 0
) (
  input logic clk,
  input logic rst,
  sort_checker_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FETCH, PRIME, SCAN, DONE} state_t;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(N - 1);
  state_t state, nxt;
  logic [ADDR_W:0] cnt;
  logic [DATA_W-1:0] prev;
  logic err, viol, last;
  always_comb begin
    nxt = IDLE;
    viol = bus.rddata < prev;
    last = cnt == LAST;
    bus.rdy = state == IDLE;
    bus.done = state == DONE;
    nxt = state == IDLE ? (bus.start ? FETCH : IDLE)
        : state == FETCH ? PRIME
        : state == PRIME ? (N == 1 ? DONE : SCAN)
        : state == SCAN ? (last ? DONE : SCAN) : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.addr <= '0;
      bus.pass <= 1'b0;
      bus.err_addr <= '0;
      bus.min_val <= '1;
      bus.max_val <= '0;
      bus.sum <= '0;
      cnt <= '0;
      prev <= '0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        bus.addr <= BASE_A;
        bus.pass <= 1'b0;
        bus.err_addr <= '0;
        bus.min_val <= '1;
        bus.max_val <= '0;
        bus.sum <= '0;
      end
      if (state == FETCH) begin
        bus.addr <= bus.addr + 1'b1;
        cnt <= (ADDR_W+1)'(1);
      end
      if (state == PRIME || state == SCAN) begin
        bus.addr <= bus.addr + 1'b1;
        prev <= bus.rddata;
        bus.sum <= bus.sum + (DATA_W+ADDR_W)'(bus.rddata);
        bus.min_val <= bus.rddata < bus.min_val ? bus.rddata : bus.min_val;
        bus.max_val <= bus.rddata > bus.max_val ? bus.rddata : bus.max_val;
      end
      if (state == PRIME) begin
        err <= 1'b0;
        bus.pass <= N == 1;
      end
      // pass is resolved on the edge into DONE so it is valid alongside the done pulse
      if (state == SCAN) begin
        cnt <= cnt + 1'b1;
        if (viol && !err) begin
          err <= 1'b1;
          bus.err_addr <= BASE_A + ADDR_W'(cnt);
        end
        if (last) bus.pass <= !(err || viol);
      end
    end
  end
endmodule

// File: tb/tb_sort_checker.sv
// tb_sort_checker: randomized and directed checks of sort_checker against a loop-based reference model
module tb_sort_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] mem [256];
  int passed = 0;
  int total = 0;
  sort_checker_if #(.ADDR_W(8), .DATA_W(8)) b0();
  sort_checker_if #(.ADDR_W(8), .DATA_W(8)) b1();
  sort_checker_if #(.ADDR_W(8), .DATA_W(8)) b2();
  sort_checker #(.ADDR_W(8), .DATA_W(8), .N(256), .BASE(0)) d0(.clk(clk), .rst(rst), .bus(b0.slave));
  sort_checker #(.ADDR_W(8), .DATA_W(8), .N(1), .BASE(128)) d1(.clk(clk), .rst(rst), .bus(b1.slave));
  sort_checker #(.ADDR_W(8), .DATA_W(8), .N(4), .BASE(254)) d2(.clk(clk), .rst(rst), .bus(b2.slave));
  always @(posedge clk) begin
    b0.rddata <= mem[b0.addr];
    b1.rddata <= mem[b1.addr];
    b2.rddata <= mem[b2.addr];
  end
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  function automatic logic rdy_of(input int w);
    return w == 0 ? b0.rdy : w == 1 ? b1.rdy : b2.rdy;
  endfunction
  function automatic logic done_of(input int w);
    return w == 0 ? b0.done : w == 1 ? b1.done : b2.done;
  endfunction
  function automatic logic [7:0] addr_of(input int w);
    return w == 0 ? b0.addr : w == 1 ? b1.addr : b2.addr;
  endfunction
  function automatic logic [40:0] res_of(input int w);
    if (w == 0) return {b0.pass, b0.err_addr, b0.min_val, b0.max_val, b0.sum};
    if (w == 1) return {b1.pass, b1.err_addr, b1.min_val, b1.max_val, b1.sum};
    return {b2.pass, b2.err_addr, b2.min_val, b2.max_val, b2.sum};
  endfunction
  task automatic set_start(input int w, input logic v);
    if (w == 0) b0.start = v;
    else if (w == 1) b1.start = v;
    else b2.start = v;
  endtask
  function automatic logic [40:0] model(input int n, input int base);
    logic ok;
    int ea, mn, mx, s, v, p;
    ok = 1'b1; ea = 0; mn = 255; mx = 0; s = 0; p = 0;
    for (int i = 0; i < n; i++) begin
      v = int'(mem[(base + i) % 256]);
      if (i > 0 && v < p && ok) begin
        ok = 1'b0;
        ea = (base + i) % 256;
      end
      mn = v < mn ? v : mn;
      mx = v > mx ? v : mx;
      s = s + v;
      p = v;
    end
    return {ok, ea[7:0], mn[7:0], mx[7:0], s[15:0]};
  endfunction
  task automatic fill_sorted(input bit perturb);
    int q[$];
    int a, b, t;
    for (int i = 0; i < 256; i++) q.push_back(int'($urandom_range(0, 255)));
    q.sort();
    for (int i = 0; i < 256; i++) mem[i] = q[i][7:0];
    if (perturb)
      repeat ($urandom_range(1, 3)) begin
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        t = mem[a];
        mem[a] = mem[b];
        mem[b] = t[7:0];
      end
  endtask
  task automatic run(input int w, input bit stray, output int lat, output int nd, output logic [31:0] seq);
    nd = 0;
    seq = '0;
    @(negedge clk);
    for (int i = 0; i < 20 && !rdy_of(w); i++) @(negedge clk);
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
    lat = 1;
    seq[24 +: 8] = addr_of(w);
    while (!done_of(w) && lat < 400) begin
      set_start(w, stray && (lat == 5 || lat == 100));
      @(negedge clk);
      lat++;
      if (lat <= 4) seq[(4 - lat) * 8 +: 8] = addr_of(w);
    end
    set_start(w, 1'b0);
    if (!done_of(w)) lat = -1;
    for (int i = 0; i < 4; i++) begin
      nd += int'(done_of(w));
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (b0.rdy !== 1'b1 || b0.done !== 1'b0) $display("FAIL reset_hs got rdy=%b done=%b want rdy=1 done=0", b0.rdy, b0.done); else passed++;
    total++; if (res_of(0) !== {1'b0, 8'h00, 8'hFF, 8'h00, 16'h0000}) $display("FAIL reset_res got %h want %h", res_of(0), {1'b0, 8'h00, 8'hFF, 8'h00, 16'h0000}); else passed++;
    total++; if (b2.addr !== 8'h00) $display("FAIL reset_addr got %h want 00", b2.addr); else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++; if (b1.rdy !== 1'b1) $display("FAIL reset_idle_rdy got %b want 1", b1.rdy); else passed++;
  endtask
  task automatic test_ascending();
    int lat, nd;
    logic [31:0] seq;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    run(0, 1'b0, lat, nd, seq);
    total++; if (lat !== 258) $display("FAIL asc_latency got %0d want 258", lat); else passed++;
    total++; if (nd !== 1) $display("FAIL asc_done_pulses got %0d want 1", nd); else passed++;
    total++; if (res_of(0) !== {1'b1, 8'h00, 8'h00, 8'hFF, 16'h7F80}) $display("FAIL asc_res got %h want %h", res_of(0), {1'b1, 8'h00, 8'h00, 8'hFF, 16'h7F80}); else passed++;
    total++; if (b0.rdy !== 1'b1) $display("FAIL asc_rdy_after got %b want 1", b0.rdy); else passed++;
  endtask
  task automatic test_violations();
    int lat, nd;
    logic [31:0] seq;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[11] = 8'h03;
    mem[200] = 8'h00;
    run(0, 1'b0, lat, nd, seq);
    total++; if (b0.pass !== 1'b0 || b0.err_addr !== 8'h0B || b0.min_val !== 8'h00) $display("FAIL viol_first got pass=%b err=%h min=%h want pass=0 err=0b min=00", b0.pass, b0.err_addr, b0.min_val); else passed++;
    total++; if (res_of(0) !== model(256, 0)) $display("FAIL viol_res got %h want %h", res_of(0), model(256, 0)); else passed++;
  endtask
  task automatic test_all_ff();
    int lat, nd;
    logic [31:0] seq;
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    run(0, 1'b0, lat, nd, seq);
    total++; if (res_of(0) !== {1'b1, 8'h00, 8'hFF, 8'hFF, 16'hFF00}) $display("FAIL allff_res got %h want %h", res_of(0), {1'b1, 8'h00, 8'hFF, 8'hFF, 16'hFF00}); else passed++;
  endtask
  task automatic test_mid_reset();
    int lat, nd;
    logic [31:0] seq;
    fill_sorted(1'b1);
    @(negedge clk);
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    lat = 1;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (b0.rdy !== 1'b1 || b0.done !== 1'b0 || b0.sum !== 16'h0 || b0.pass !== 1'b0) $display("FAIL midrst_state got rdy=%b done=%b sum=%h pass=%b want 1 0 0000 0", b0.rdy, b0.done, b0.sum, b0.pass); else passed++;
    total++; if (b0.min_val !== 8'hFF || b0.max_val !== 8'h00 || b0.addr !== 8'h00) $display("FAIL midrst_regs got min=%h max=%h addr=%h want ff 00 00", b0.min_val, b0.max_val, b0.addr); else passed++;
    run(0, 1'b0, lat, nd, seq);
    total++; if (lat !== 258 || res_of(0) !== model(256, 0)) $display("FAIL midrst_rerun got lat=%0d res=%h want lat=258 res=%h", lat, res_of(0), model(256, 0)); else passed++;
  endtask
  task automatic test_stray_start();
    int lat, nd;
    logic [31:0] seq;
    fill_sorted(1'b0);
    run(0, 1'b1, lat, nd, seq);
    total++; if (lat !== 258 || nd !== 1) $display("FAIL stray_timing got lat=%0d pulses=%0d want 258 1", lat, nd); else passed++;
    total++; if (res_of(0) !== model(256, 0)) $display("FAIL stray_res got %h want %h", res_of(0), model(256, 0)); else passed++;
  endtask
  task automatic test_single();
    int lat, nd;
    logic [31:0] seq;
    mem[8'h80] = 8'h42;
    run(1, 1'b0, lat, nd, seq);
    total++; if (lat !== 3 || nd !== 1) $display("FAIL single_timing got lat=%0d pulses=%0d want 3 1", lat, nd); else passed++;
    total++; if (res_of(1) !== {1'b1, 8'h00, 8'h42, 8'h42, 16'h0042}) $display("FAIL single_res got %h want %h", res_of(1), {1'b1, 8'h00, 8'h42, 8'h42, 16'h0042}); else passed++;
  endtask
  task automatic test_wrap();
    int lat, nd;
    logic [31:0] seq;
    mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h02; mem[8'h00] = 8'h07; mem[8'h01] = 8'h03;
    run(2, 1'b0, lat, nd, seq);
    total++; if (seq !== 32'hFEFF0001) $display("FAIL wrap_addr_seq got %h want feff0001", seq); else passed++;
    total++; if (lat !== 6) $display("FAIL wrap_latency got %0d want 6", lat); else passed++;
    total++; if (res_of(2) !== {1'b0, 8'h01, 8'h01, 8'h07, 16'h000D}) $display("FAIL wrap_res got %h want %h", res_of(2), {1'b0, 8'h01, 8'h01, 8'h07, 16'h000D}); else passed++;
    for (int k = 0; k < 6; k++) begin
      foreach (mem[i]) mem[i] = 8'($urandom_range(0, 255));
      run(2, 1'b0, lat, nd, seq);
      total++; if (res_of(2) !== model(4, 254)) $display("FAIL wrap_rand%0d got %h want %h", k, res_of(2), model(4, 254)); else passed++;
    end
  endtask
  task automatic test_random();
    int lat, nd;
    logic [31:0] seq;
    for (int k = 0; k < 8; k++) begin
      fill_sorted(k[0]);
      run(0, 1'b0, lat, nd, seq);
      total++; if (lat !== 258 || res_of(0) !== model(256, 0)) $display("FAIL rand%0d got lat=%0d res=%h want lat=258 res=%h", k, lat, res_of(0), model(256, 0)); else passed++;
    end
  endtask
  task automatic test_back_to_back();
    logic [15:0] mask;
    mask = '0;
    mem[8'h80] = 8'($urandom_range(0, 255));
    @(negedge clk);
    b1.start = 1'b1;
    for (int lat = 1; lat <= 12; lat++) begin
      @(negedge clk);
      if (b1.done) mask[lat] = 1'b1;
    end
    b1.start = 1'b0;
    total++; if (mask !== 16'h0888) $display("FAIL b2b_done_mask got %h want 0888", mask); else passed++;
    total++; if (res_of(1) !== model(1, 128)) $display("FAIL b2b_res got %h want %h", res_of(1), model(1, 128)); else passed++;
    repeat (4) @(negedge clk);
  endtask
  initial begin
    b0.start = 1'b0;
    b1.start = 1'b0;
    b2.start = 1'b0;
    foreach (mem[i]) mem[i] = 8'h00;
    test_reset();
    test_ascending();
    test_violations();
    test_all_ff();
    test_mid_reset();
    test_stray_start();
    test_single();
    test_wrap();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
